layer6_buffer_ctrl: RTL and testbench
=====================================

LAYER6_BUFFER_CTRL -- requirements
Module: layer6_buffer_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports CK and RSTN.
REQ-002 CK  in  1  clock; both SRAM ports run on CK.
REQ-003 RSTN  in  1  asynchronous, active-low reset.
REQ-004 clear  in  1  single-cycle pulse; restart the fill of a new layer.
REQ-005 wr_valid/wr_ready  in/out  1/1  write handshake from the producer layer.
REQ-006 wr_data  in  128  one layer6 word.
REQ-007 rd_req_valid/rd_req_ready  in/out  1/1  read-request handshake from the consumer.
REQ-008 rd_req_addr  in  6  word address to read.
REQ-009 rd_valid/rd_ready  out/in  1/1  read-data handshake.
REQ-010 rd_data  out  128  returned word.
REQ-011 layer_done  out  1  high while all 64 words are written.
REQ-012 sram_A, sram_B (out, 6), sram_WEAN, sram_WEBN, sram_OEA, sram_OEB (out, 1), sram_DIA, sram_DIB (out, 128), sram_DOB (in, 128): drive the layer6 SRAM wrapper.

Function
REQ-013 Port A SHALL be write-only: sram_OEA=0, sram_DIA=wr_data, sram_WEAN=!(wr_valid&&wr_ready).
REQ-014 Port B SHALL be read-only: sram_WEBN=1, sram_DIB=0, sram_OEB=1 only in a cycle where a read request is accepted.
REQ-015 The FSM SHALL have two states: FILL and DONE. Reset state is FILL.
REQ-016 In FILL: wr_ready=1, and wr_ptr (7-bit counter) increments on each write; on the 64th write the FSM SHALL enter DONE next cycle.
REQ-017 In DONE: wr_ready=0 and layer_done=1.
REQ-018 A clear pulse in any state SHALL force FILL and wr_ptr=0 next cycle. An accepted read in flight SHALL still complete.
REQ-019 If a write fires in the same cycle as clear, the write SHALL reach the SRAM and SHALL NOT be counted.
REQ-020 sram_A SHALL equal wr_ptr[5:0].
REQ-021 sram_B SHALL equal the accepted rd_req_addr. When no read is accepted, sram_B SHALL be sram_A with bit0 inverted, so sram_B never equals sram_A while sram_WEAN=0.
REQ-022 rd_req_ready SHALL be 1 only when both hold: rd_req_addr<wr_ptr (written data only), and the output skid buffer holds fewer than 2 entries counting in-flight reads.
REQ-023 Read latency SHALL be exactly one cycle from request acceptance to rd_valid, when the output is not back-pressured.
REQ-024 The output SHALL use a 2-entry FIFO skid buffer. rd_data and rd_valid SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-025 Data SHALL be returned in request order.
REQ-026 Simultaneous read and write to different addresses SHALL both proceed in one cycle.

Reset
REQ-027 On RSTN=0, all of the following SHALL be cleared asynchronously: FSM=FILL, wr_ptr=0, skid buffer empty, in-flight flag 0.
REQ-028 During reset, outputs SHALL be: rd_valid=0, rd_data=0, layer_done=0, wr_ready=0, sram_WEAN=1, sram_OEB=0.
REQ-029 wr_ready SHALL rise on the first CK edge after RSTN is deasserted.

Configuration
REQ-030 With macro LAYER6_FWD_EN defined, a read with rd_req_addr==wr_ptr SHALL be accepted in a cycle where a write fires. rd_data SHALL then come from a registered copy of wr_data, sram_OEB=0, and sram_B SHALL be sram_A with bit0 inverted. Latency stays one cycle.
REQ-031 Without LAYER6_FWD_EN, such a read SHALL be stalled (rd_req_ready=0) until the write completes. The read then proceeds from the SRAM.

Structure
REQ-032 A shared package layer6_pkg SHALL hold: L6_WORDS=64, L6_AW=6, L6_DW=128, and the FSM state enum.
REQ-033 The 2-entry skid buffer SHALL be one sub-module, layer6_skid_buf, parameterised by width.

Verification
REQ-034 Write 64 words with value i; assert layer_done one cycle after the last write, then assert wr_ready=0.
REQ-035 After fill, read addresses 63 down to 0 with rd_ready=1: each rd_data=i, one cycle after request, in order.
REQ-036 Read addr 5 while wr_ptr=3: rd_req_ready=0 until wr_ptr=6.
REQ-037 Hold rd_ready=0 for 4 cycles with requests pending: at most 2 accepted, rd_data held stable, no loss after release.
REQ-038 Read addr 7 in the same cycle as the write of 7 (0xABCD…): with LAYER6_FWD_EN, data returns in 1 cycle; without it, the read stalls 1 cycle. sram_A!=sram_B whenever sram_WEAN=0.
REQ-039 Assert RSTN mid-read and clear mid-fill: outputs match REQ-028/REQ-018, and wr_ptr restarts at 0.

Source files
------------

// File: rtl/layer6_pkg.sv
// Shared constants and FSM state type for the layer6 activation buffer controller.
package layer6_pkg;

    localparam int L6_WORDS = 64;
    localparam int L6_AW    = 6;
    localparam int L6_DW    = 128;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } l6_state_e;

endpackage

// File: rtl/layer6_skid_buf.sv
// Two-entry fall-through FIFO on the read-data path; an empty buffer passes
// incoming data straight to the output so the SRAM read costs a single cycle.
module layer6_skid_buf #(
    parameter int W = 128
) (
    input  logic         CK,
    input  logic         RSTN,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   cnt;
    logic         push;
    logic         pop;

    always_comb begin
        out_valid = (cnt != 2'd0) || in_valid;
        out_data  = '0;
        if (cnt != 2'd0) begin
            out_data = head;
        end else if (in_valid) begin
            out_data = in_data;
        end
        // Incoming data is stored unless it flows through to a ready consumer.
        push = in_valid && !((cnt == 2'd0) && out_ready);
        pop  = (cnt != 2'd0) && out_ready;
    end

    assign count = cnt;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            cnt  <= 2'd0;
            head <= '0;
            tail <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        head <= in_data;
                    end else begin
                        tail <= in_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/layer6_buffer_ctrl.sv
// Layer6 activation buffer: fills 64 words through SRAM port A, serves reads via port B.
// Build option LAYER6_FWD_EN forwards a read of the word being written this cycle.
//
//   state | meaning
//   FILL  | accepting writes, wr_ptr counts words written
//   DONE  | all 64 words written, writes blocked until clear
module layer6_buffer_ctrl
    import layer6_pkg::*;
(
    input  logic             CK,
    input  logic             RSTN,
    input  logic             clear,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [L6_DW-1:0] wr_data,
    input  logic             rd_req_valid,
    output logic             rd_req_ready,
    input  logic [L6_AW-1:0] rd_req_addr,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [L6_DW-1:0] rd_data,
    output logic             layer_done,
    output logic [L6_AW-1:0] sram_A,
    output logic [L6_AW-1:0] sram_B,
    output logic             sram_WEAN,
    output logic             sram_WEBN,
    output logic             sram_OEA,
    output logic             sram_OEB,
    output logic [L6_DW-1:0] sram_DIA,
    output logic [L6_DW-1:0] sram_DIB,
    input  logic [L6_DW-1:0] sram_DOB
);

    l6_state_e        state;
    logic [L6_AW:0]   wr_ptr;
    logic             wr_fire;
    logic             rd_fire;
    logic             fwd_hit;
    logic             addr_written;
    logic             credit_ok;
    logic             inflight_q;
    logic [1:0]       skid_cnt;
    logic [L6_DW-1:0] skid_in;

    assign wr_fire      = wr_valid && wr_ready;
    assign addr_written = {1'b0, rd_req_addr} < wr_ptr;
    // Reserve a skid slot for every read already issued to the SRAM.
    assign credit_ok    = (skid_cnt + {1'b0, inflight_q}) < 2'd2;
    assign rd_req_ready = (addr_written || fwd_hit) && credit_ok;
    assign rd_fire      = rd_req_valid && rd_req_ready;

    assign sram_A    = wr_ptr[L6_AW-1:0];
    assign sram_WEAN = !wr_fire;
    assign sram_OEA  = 1'b0;
    assign sram_DIA  = wr_data;
    assign sram_WEBN = 1'b1;
    assign sram_DIB  = '0;
    assign sram_OEB  = rd_fire && !fwd_hit;
    // Idle port B parks on the neighbour of the write address to avoid a collision.
    assign sram_B    = (rd_fire && !fwd_hit) ? rd_req_addr
                                             : {wr_ptr[L6_AW-1:1], ~wr_ptr[0]};

`ifdef LAYER6_FWD_EN
    logic             fwd_q;
    logic [L6_DW-1:0] fwd_data_q;

    assign fwd_hit = wr_fire && ({1'b0, rd_req_addr} == wr_ptr);
    assign skid_in = fwd_q ? fwd_data_q : sram_DOB;

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q <= rd_fire && fwd_hit;
            if (rd_fire && fwd_hit) begin
                fwd_data_q <= wr_data;
            end
        end
    end
`else
    assign fwd_hit = 1'b0;
    assign skid_in = sram_DOB;
`endif

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= rd_fire;
        end
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= FILL;
            wr_ptr     <= '0;
            wr_ready   <= 1'b0;
            layer_done <= 1'b0;
        end else if (clear) begin
            // A write coinciding with clear still lands in the SRAM but is not counted.
            state      <= FILL;
            wr_ptr     <= '0;
            wr_ready   <= 1'b1;
            layer_done <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    wr_ready   <= 1'b1;
                    layer_done <= 1'b0;
                    if (wr_fire) begin
                        wr_ptr <= wr_ptr + 7'd1;
                        if (wr_ptr == 7'(L6_WORDS - 1)) begin
                            state      <= DONE;
                            wr_ready   <= 1'b0;
                            layer_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    wr_ready   <= 1'b0;
                    layer_done <= 1'b1;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

    layer6_skid_buf #(
        .W(L6_DW)
    ) u_skid (
        .CK        (CK),
        .RSTN      (RSTN),
        .in_valid  (inflight_q),
        .in_data   (skid_in),
        .out_valid (rd_valid),
        .out_data  (rd_data),
        .out_ready (rd_ready),
        .count     (skid_cnt)
    );

endmodule

// File: tb/tb_layer6_buffer_ctrl.sv
// Directed bench for layer6_buffer_ctrl with an SRAM model and an in-order read scoreboard.
module tb_layer6_buffer_ctrl;
    import layer6_pkg::*;

`ifdef LAYER6_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic             CK = 1'b0;
    logic             RSTN;
    logic             clear;
    logic             wr_valid;
    logic             wr_ready;
    logic [L6_DW-1:0] wr_data;
    logic             rd_req_valid;
    logic             rd_req_ready;
    logic [L6_AW-1:0] rd_req_addr;
    logic             rd_valid;
    logic             rd_ready;
    logic [L6_DW-1:0] rd_data;
    logic             layer_done;
    logic [L6_AW-1:0] sram_A;
    logic [L6_AW-1:0] sram_B;
    logic             sram_WEAN;
    logic             sram_WEBN;
    logic             sram_OEA;
    logic             sram_OEB;
    logic [L6_DW-1:0] sram_DIA;
    logic [L6_DW-1:0] sram_DIB;
    logic [L6_DW-1:0] sram_DOB;

    always #5 CK = ~CK;

    layer6_buffer_ctrl dut (
        .CK           (CK),
        .RSTN         (RSTN),
        .clear        (clear),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .layer_done   (layer_done),
        .sram_A       (sram_A),
        .sram_B       (sram_B),
        .sram_WEAN    (sram_WEAN),
        .sram_WEBN    (sram_WEBN),
        .sram_OEA     (sram_OEA),
        .sram_OEB     (sram_OEB),
        .sram_DIA     (sram_DIA),
        .sram_DIB     (sram_DIB),
        .sram_DOB     (sram_DOB)
    );

    logic [L6_DW-1:0] sram_mem [L6_WORDS];

    always @(posedge CK) begin
        if (!sram_WEAN) sram_mem[sram_A] <= sram_DIA;
        if (sram_OEB)   sram_DOB <= sram_mem[sram_B];
    end

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        chk(tag, 128'(got), 128'(exp));
    endtask

    task automatic cyc();
        @(posedge CK);
        #1;
    endtask

    function automatic logic [127:0] wval(input int i);
        return (i == 7) ? {8{16'hABCD}} : 128'(i);
    endfunction

    logic [L6_DW-1:0] exp_mem [L6_WORDS];
    logic [L6_DW-1:0] sb [$];
    logic [L6_AW:0]   mdl_ptr;
    logic             held;
    logic [L6_DW-1:0] held_data;
    logic [L6_DW-1:0] exp_rd;

    always @(negedge CK) begin
        if (!RSTN) begin
            sb.delete();
            mdl_ptr = '0;
            held    = 1'b0;
        end else begin
            chk("sram_a", 128'(sram_A), 128'(mdl_ptr[L6_AW-1:0]));
            if (!sram_WEAN) chkb("a_ne_b", sram_A != sram_B, 1'b1);
            if (held) begin
                chkb("hold_valid", rd_valid, 1'b1);
                chk("hold_data", rd_data, held_data);
            end
            held      = rd_valid && !rd_ready;
            held_data = rd_data;
            if (rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    n_fail++;
                    $error("FAIL sb_underflow: observed %0h expected no data", rd_data);
                end else begin
                    exp_rd = sb.pop_front();
                    chk("rd_data", rd_data, exp_rd);
                end
            end
            if (wr_valid && wr_ready) exp_mem[mdl_ptr[L6_AW-1:0]] = wr_data;
            if (rd_req_valid && rd_req_ready) sb.push_back(exp_mem[rd_req_addr]);
            if (clear) mdl_ptr = '0;
            else if (wr_valid && wr_ready) mdl_ptr = mdl_ptr + 7'd1;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    int  n_acc;
    logic acc;

    initial begin
        RSTN = 1'b0; clear = 1'b0; wr_valid = 1'b1; wr_data = '0;
        rd_req_valid = 1'b0; rd_req_addr = '0; rd_ready = 1'b1;

        // Reset values
        @(negedge CK);
        @(negedge CK);
        chkb("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        chkb("rst_layer_done", layer_done, 1'b0);
        chkb("rst_wr_ready", wr_ready, 1'b0);
        chkb("rst_wean", sram_WEAN, 1'b1);
        chkb("rst_oeb", sram_OEB, 1'b0);
        #1;
        RSTN = 1'b1;
        wr_valid = 1'b0;
        #1;
        chkb("wr_ready_before_edge", wr_ready, 1'b0);
        cyc();
        chkb("wr_ready_first_edge", wr_ready, 1'b1);

        // Fill with interleaved read probes
        for (int i = 0; i < L6_WORDS; i++) begin
            rd_req_valid = 1'b0;
            if (i == 5) begin
                wr_valid = 1'b0;
                rd_req_valid = 1'b1; rd_req_addr = 6'd5;
                @(negedge CK);
                chkb("stall_idle5", rd_req_ready, 1'b0);
                cyc();
            end
            wr_valid = 1'b1;
            wr_data  = wval(i);
            if (i == 3 || i == 4 || i == 5 || i == 6) begin
                rd_req_valid = 1'b1; rd_req_addr = 6'd5;
            end
            if (i == 7) begin
                rd_req_valid = 1'b1; rd_req_addr = 6'd7;
            end
`ifndef LAYER6_FWD_EN
            if (i == 8) begin
                rd_req_valid = 1'b1; rd_req_addr = 6'd7;
            end
`endif
            @(negedge CK);
            if (i == 3 || i == 4) chkb("stall_unwritten", rd_req_ready, 1'b0);
            if (i == 5) chkb("same_addr5_ready", rd_req_ready, FWD);
            if (i == 6) begin
                chkb("ready_at6", rd_req_ready, 1'b1);
                chkb("fwd5_latency", rd_valid, FWD);
            end
            if (i == 7) begin
                chkb("lat_rd6", rd_valid, 1'b1);
                chkb("same_addr7_ready", rd_req_ready, FWD);
`ifdef LAYER6_FWD_EN
                chkb("fwd7_oeb", sram_OEB, 1'b0);
                chk("fwd7_b", 128'(sram_B), 128'(6'd6));
`endif
            end
            if (i == 8) begin
                chkb("fwd7_latency", rd_valid, FWD);
`ifndef LAYER6_FWD_EN
                chkb("stall7_ready", rd_req_ready, 1'b1);
                chkb("stall7_oeb", sram_OEB, 1'b1);
                chk("stall7_b", 128'(sram_B), 128'(6'd7));
`endif
            end
`ifndef LAYER6_FWD_EN
            if (i == 9) chkb("stall7_latency", rd_valid, 1'b1);
`endif
            if (i == 63) chkb("done_before_last", layer_done, 1'b0);
            cyc();
        end
        rd_req_valid = 1'b0;
        wr_data = 128'd999;
        @(negedge CK);
        chkb("layer_done", layer_done, 1'b1);
        chkb("done_wr_ready", wr_ready, 1'b0);
        chkb("done_wean", sram_WEAN, 1'b1);
        cyc();
        wr_valid = 1'b0;

        // Read-back sweep 63..0
        for (int a = 63; a >= 0; a--) begin
            rd_req_valid = 1'b1;
            rd_req_addr  = 6'(a);
            @(negedge CK);
            chkb("sweep_ready", rd_req_ready, 1'b1);
            if (a != 63) chkb("sweep_latency", rd_valid, 1'b1);
            cyc();
        end
        rd_req_valid = 1'b0;
        @(negedge CK);
        chkb("sweep_last", rd_valid, 1'b1);
        cyc();
        cyc();

        // Back-pressure: at most two reads accepted
        rd_ready = 1'b0;
        rd_req_addr = 6'd10;
        n_acc = 0;
        for (int k = 0; k < 4; k++) begin
            rd_req_valid = 1'b1;
            @(negedge CK);
            acc = rd_req_ready;
            if (acc) n_acc++;
            cyc();
            if (acc) rd_req_addr = rd_req_addr + 6'd1;
        end
        chk("bp_accepted", 128'(n_acc), 128'd2);
        rd_req_valid = 1'b0;
        rd_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (sb.size() == 0) break;
        end
        chk("bp_drain", 128'(sb.size()), 128'd0);

        // Clear in DONE with a read accepted the same cycle
        clear = 1'b1; wr_valid = 1'b1; wr_data = 128'd777;
        rd_req_valid = 1'b1; rd_req_addr = 6'd20;
        @(negedge CK);
        chkb("clr_rd_ready", rd_req_ready, 1'b1);
        cyc();
        clear = 1'b0; wr_valid = 1'b0;
        rd_req_addr = 6'd0;
        @(negedge CK);
        chkb("clr_layer_done", layer_done, 1'b0);
        chkb("clr_wr_ready", wr_ready, 1'b1);
        chk("clr_ptr", 128'(sram_A), 128'd0);
        chkb("clr_inflight", rd_valid, 1'b1);
        chkb("clr_unwritten", rd_req_ready, 1'b0);
        cyc();
        rd_req_valid = 1'b0;

        // Clear colliding with a write
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = 128'(200 + i);
            cyc();
        end
        clear = 1'b1; wr_data = 128'd555;
        @(negedge CK);
        chkb("clrwr_wean", sram_WEAN, 1'b0);
        chk("clrwr_addr", 128'(sram_A), 128'd5);
        cyc();
        clear = 1'b0; wr_valid = 1'b0;
        @(negedge CK);
        chk("clrwr_ptr", 128'(sram_A), 128'd0);
        cyc();

        // Reset while a read sits in the skid buffer
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = 128'(300 + i);
            cyc();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        rd_req_valid = 1'b1; rd_req_addr = 6'd1;
        cyc();
        rd_req_valid = 1'b0;
        @(negedge CK);
        chkb("pre_rst_valid", rd_valid, 1'b1);
        cyc();
        wr_valid = 1'b1;
        #1;
        RSTN = 1'b0;
        #1;
        chkb("mid_rst_rd_valid", rd_valid, 1'b0);
        chk("mid_rst_rd_data", rd_data, '0);
        chkb("mid_rst_layer_done", layer_done, 1'b0);
        chkb("mid_rst_wr_ready", wr_ready, 1'b0);
        chkb("mid_rst_wean", sram_WEAN, 1'b1);
        chkb("mid_rst_oeb", sram_OEB, 1'b0);
        chk("mid_rst_ptr", 128'(sram_A), 128'd0);
        @(negedge CK);
        #1;
        RSTN = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        cyc();
        chkb("post_rst_wr_ready", wr_ready, 1'b1);
        chkb("post_rst_rd_valid", rd_valid, 1'b0);
        chk("post_rst_ptr", 128'(sram_A), 128'd0);
        cyc();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
